// File: rtl/mixcol_seq.sv
// rtl/mixcol_seq.sv - sequenced MixColumns/InvMixColumns engine, one column per cycle
module mixcol_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [1:0]    col_q;
    logic          mode_q;
    logic [127:0]  work_q;
    logic [127:0]  out_q;

    logic [31:0]   col_s;
    logic [31:0]   col_r;

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] enc_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        enc_col[31:24] = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
        enc_col[23:16] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
        enc_col[15:8]  = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
        enc_col[7:0]   = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
    endfunction

    // x9/x11/x13/x14 are assembled from the x2/x4/x8 xtime chain of each byte
    function automatic logic [31:0] dec_col(input logic [31:0] c);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]   = c[31-8*i -: 8];
            x2     = xt(s[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ s[i];
            m11[i] = x8 ^ x2 ^ s[i];
            m13[i] = x8 ^ x4 ^ s[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        dec_col[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
        dec_col[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
        dec_col[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
        dec_col[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    endfunction

    always_comb begin
        col_s = work_q[127:96];
        case (col_q)
            2'd0: col_s = work_q[127:96];
            2'd1: col_s = work_q[95:64];
            2'd2: col_s = work_q[63:32];
            2'd3: col_s = work_q[31:0];
            default: col_s = work_q[127:96];
        endcase
        col_r = mode_q ? dec_col(col_s) : enc_col(col_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            mode_q  <= 1'b0;
            work_q  <= 128'h0;
            out_q   <= 128'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= state_in;
                        mode_q  <= inv;
                        col_q   <= 2'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    case (col_q)
                        2'd0: work_q[127:96] <= col_r;
                        2'd1: work_q[95:64]  <= col_r;
                        2'd2: work_q[63:32]  <= col_r;
                        2'd3: work_q[31:0]   <= col_r;
                        default: work_q[127:96] <= col_r;
                    endcase
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        out_q   <= {work_q[127:32], col_r};
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign state_out = out_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// tb/tb_mixcol_seq.sv - directed self-checking bench for mixcol_seq
module tb_mixcol_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] FIXED    = 128'h01010101_c6c6c6c6_01010101_c6c6c6c6;

    mixcol_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bitwise GF(2^8) shift-and-add multiply with a circulant coefficient row
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic m);
        logic [7:0] coef [4];
        logic [7:0] s [4];
        logic [7:0] r;
        logic [127:0] res;
        if (m) begin
            coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
        end else begin
            coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) s[j] = st[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j-i+4)%4], s[j]);
                res[127-32*c-8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] din, input logic m, input logic [127:0] exp,
                             input string tag, input bit toggle);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, {127'h0, in_ready}, 128'h1);
        state_in = din;
        inv      = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        state_in = ~din;
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (toggle) inv = ~inv;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd5);
        chk({tag, "_result"}, state_out, exp);
        chk({tag, "_busy"}, {127'h0, busy}, 128'h1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drained"}, {126'h0, out_valid, in_ready}, 128'h1);
        chk({tag, "_hold"}, state_out, exp);
    endtask

    initial begin
        logic [127:0] vec [4];
        logic         md [4];
        int           acc [4];
        int           k, r;
        logic [127:0] bp_new;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        state_in  = '0;
        inv       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
        chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset_busy", {127'h0, busy}, 128'h0);
        chk("reset_state_out", state_out, 128'h0);

        run_block(FIPS_IN, 1'b0, FIPS_OUT, "fips_enc", 1'b0);
        run_block(FIPS_OUT, 1'b1, FIPS_IN, "fips_dec", 1'b0);
        run_block(FIXED, 1'b0, FIXED, "fixed_pt", 1'b0);
        run_block(FIPS_IN, 1'b0, FIPS_OUT, "mode_latch_enc", 1'b1);
        run_block(FIPS_OUT, 1'b1, FIPS_IN, "mode_latch_dec", 1'b1);

        // Abort mid-run with an asynchronous reset pulse
        @(negedge clk);
        state_in = FIPS_IN;
        inv      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_idle", {125'h0, in_ready, out_valid, busy}, 128'h4);
        chk("abort_state_out", state_out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("abort_no_out_valid", 128'(seen), 128'd0);
        end

        // Backpressure: result held while new input is offered and refused
        bp_new = 128'h00112233_44556677_8899aabb_ccddeeff;
        @(negedge clk);
        state_in = FIPS_IN;
        inv      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        state_in = bp_new;
        inv      = 1'b1;
        repeat (3) @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (!out_valid || in_ready || state_out !== FIPS_OUT) bad++;
            end
            chk("bp_stable", 128'(bad), 128'd0);
        end
        chk("bp_result", state_out, FIPS_OUT);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", {126'h0, in_ready, out_valid}, 128'h2);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept", {126'h0, busy, in_ready}, 128'h2);
        begin
            int lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("bp_latency", 128'(lat), 128'd5);
        end
        chk("bp_pending_result", state_out, model(bp_new, 1'b1));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Back-to-back with in_valid and out_ready held high
        vec[0] = 128'h3a7f19c2_5be0d486_0f21c3e4_97aa5b10; md[0] = 1'b0;
        vec[1] = 128'hfe01dc23_ba456789_13579bdf_02468ace; md[1] = 1'b1;
        vec[2] = 128'h80808080_7f7f7f7f_ffffffff_00000001; md[2] = 1'b0;
        vec[3] = 128'hc0ffee00_deadbeef_0badf00d_8badcafe; md[3] = 1'b1;
        k = 0;
        r = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid && r < 4) begin
                chk($sformatf("b2b_result%0d", r), state_out, model(vec[r], md[r]));
                r++;
            end
            if (in_ready) begin
                if (k < 4) begin
                    state_in = vec[k];
                    inv      = md[k];
                    in_valid = 1'b1;
                    acc[k]   = cyc;
                    if (k > 0) chk($sformatf("b2b_spacing%0d", k), 128'(acc[k] - acc[k-1]), 128'd6);
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(k), 128'd4);
        chk("b2b_results", 128'(r), 128'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
